// File: rtl/mips_pc_unit.sv
// Program-counter unit for the multicycle MIPS core: next-address selection,
// optional branch delay slot, EPC/BD capture and halt-at-zero detection.
module mips_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter bit          DELAY_SLOT   = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cnt_en,
    input  logic [1:0]  i_pc_ctrl,
    input  logic [31:0] i_read_data_1,
    input  logic [15:0] i_signed_offset,
    input  logic [25:0] i_target,
    input  logic        i_exc_req,
    output logic [31:0] o_pc,
    output logic        o_in_slot,
    output logic [31:0] o_epc,
    output logic        o_bd,
    output logic        o_addr_err,
    output logic        o_active,
    output logic [1:0]  o_state
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SLOT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_pending, r_epc;
    logic [31:0] w_pc_nxt, w_pending_nxt, w_epc_nxt;
    logic        r_bd, r_addr_err;
    logic        w_bd_nxt, w_addr_err_nxt;
    logic [31:0] w_pc_plus4, w_branch_off, w_target;
    logic        w_misaligned;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_branch_off = {{14{i_signed_offset[15]}}, i_signed_offset, 2'b00};
    assign w_misaligned = (i_pc_ctrl == 2'b10) && (i_read_data_1[1:0] != 2'b00);

    always_comb begin
        w_target = w_pc_plus4 + w_branch_off;
        case (i_pc_ctrl)
            2'b01:   w_target = {w_pc_plus4[31:28], i_target, 2'b00};
            2'b10:   w_target = i_read_data_1;
            default: w_target = w_pc_plus4 + w_branch_off;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_VECTOR;
            r_pending  <= '0;
            r_epc      <= '0;
            r_bd       <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pending  <= w_pending_nxt;
            r_epc      <= w_epc_nxt;
            r_bd       <= w_bd_nxt;
            r_addr_err <= w_addr_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pending_nxt  = r_pending;
        w_epc_nxt      = r_epc;
        w_bd_nxt       = r_bd;
        w_addr_err_nxt = r_addr_err;
        if (i_cnt_en) begin
            w_addr_err_nxt = 1'b0;
            if (r_state != ST_HALT) begin
                if (i_exc_req || w_misaligned) begin
                    // A real exception in the slot blames the branch; an address error blames the jr itself.
                    w_pc_nxt       = EXC_VECTOR;
                    w_state_nxt    = ST_RUN;
                    w_pending_nxt  = '0;
                    w_bd_nxt       = i_exc_req && (r_state == ST_SLOT);
                    w_epc_nxt      = w_bd_nxt ? (r_pc - 32'd4) : r_pc;
                    w_addr_err_nxt = !i_exc_req;
                end else begin
                    if (r_state == ST_SLOT) begin
                        w_pc_nxt      = r_pending;
                        w_pending_nxt = '0;
                        w_state_nxt   = ST_RUN;
                    end else if (i_pc_ctrl != 2'b11) begin
                        if (DELAY_SLOT) begin
                            w_pc_nxt      = w_pc_plus4;
                            w_pending_nxt = w_target;
                            w_state_nxt   = ST_SLOT;
                        end else begin
                            w_pc_nxt = w_target;
                        end
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                    // Reaching address 0 by normal flow halts the core.
                    if (w_pc_nxt == 32'd0) begin
                        w_state_nxt   = ST_HALT;
                        w_pending_nxt = '0;
                    end
                end
            end
        end
    end

    always_comb begin
        o_pc       = r_pc;
        o_epc      = r_epc;
        o_bd       = r_bd;
        o_addr_err = r_addr_err;
        o_in_slot  = (r_state == ST_SLOT);
        o_active   = (r_state != ST_HALT);
        o_state    = r_state;
    end
endmodule

// File: tb/tb_mips_pc_unit.sv
// Bench for mips_pc_unit: one delay-slot and one immediate-redirect instance
// share stimulus; a reference model feeds a scoreboard checked by a monitor.
module tb_mips_pc_unit;
    localparam int W = 68;
    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic [31:0] EV = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cnt_en = 1'b0;
    logic [1:0]  pc_ctrl = 2'b11;
    logic [31:0] read_data_1 = '0;
    logic [15:0] signed_offset = '0;
    logic [25:0] target = '0;
    logic        exc_req = 1'b0;

    logic [31:0] pc1, epc1, pc0, epc0;
    logic        slot1, bd1, aerr1, act1, slot0, bd0, aerr0, act0;
    logic [1:0]  st1, st0;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q0[$];

    // Reference model state, index 1 = delay slot enabled, 0 = immediate.
    logic [31:0] m_pc[2], m_pend[2], m_epc[2];
    logic        m_slot[2], m_bd[2], m_aerr[2], m_halted[2];

    always #5 clk = ~clk;

    mips_pc_unit #(.RESET_VECTOR(RV), .EXC_VECTOR(EV), .DELAY_SLOT(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_cnt_en(cnt_en), .i_pc_ctrl(pc_ctrl),
        .i_read_data_1(read_data_1), .i_signed_offset(signed_offset),
        .i_target(target), .i_exc_req(exc_req),
        .o_pc(pc1), .o_in_slot(slot1), .o_epc(epc1), .o_bd(bd1),
        .o_addr_err(aerr1), .o_active(act1), .o_state(st1)
    );

    mips_pc_unit #(.RESET_VECTOR(RV), .EXC_VECTOR(EV), .DELAY_SLOT(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_cnt_en(cnt_en), .i_pc_ctrl(pc_ctrl),
        .i_read_data_1(read_data_1), .i_signed_offset(signed_offset),
        .i_target(target), .i_exc_req(exc_req),
        .o_pc(pc0), .o_in_slot(slot0), .o_epc(epc0), .o_bd(bd0),
        .o_addr_err(aerr0), .o_active(act0), .o_state(st0)
    );

    function automatic logic [W-1:0] model_out(input int k);
        return {m_pc[k], m_slot[k], m_epc[k], m_bd[k], m_aerr[k], ~m_halted[k]};
    endfunction

    task automatic model_step(input int k, input bit ds);
        logic [31:0] p, t;
        p = m_pc[k];
        if (rst) begin
            m_pc[k] = RV; m_pend[k] = '0; m_epc[k] = '0;
            m_slot[k] = 1'b0; m_bd[k] = 1'b0; m_aerr[k] = 1'b0; m_halted[k] = 1'b0;
        end else if (cnt_en) begin
            m_aerr[k] = 1'b0;
            if (!m_halted[k]) begin
                if (pc_ctrl == 2'd0) t = p + 32'd4 + 32'($signed(signed_offset)) * 32'd4;
                else if (pc_ctrl == 2'd1) t = {4'(((p + 32'd4) >> 28)), target, 2'b00};
                else t = read_data_1;
                if (exc_req) begin
                    m_epc[k] = m_slot[k] ? p - 32'd4 : p;
                    m_bd[k] = m_slot[k];
                    m_pc[k] = EV; m_slot[k] = 1'b0;
                end else if (pc_ctrl == 2'd2 && read_data_1 % 4 != 0) begin
                    m_epc[k] = p; m_bd[k] = 1'b0; m_aerr[k] = 1'b1;
                    m_pc[k] = EV; m_slot[k] = 1'b0;
                end else begin
                    if (m_slot[k]) begin
                        m_pc[k] = m_pend[k]; m_slot[k] = 1'b0;
                    end else if (pc_ctrl == 2'd3) begin
                        m_pc[k] = p + 32'd4;
                    end else if (ds) begin
                        m_pc[k] = p + 32'd4; m_pend[k] = t; m_slot[k] = 1'b1;
                    end else begin
                        m_pc[k] = t;
                    end
                    if (m_pc[k] == 32'd0) begin
                        m_halted[k] = 1'b1; m_slot[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic drive(input bit r, input bit en, input logic [1:0] ctrl,
                         input logic [31:0] rd, input logic [15:0] off,
                         input logic [25:0] tgt, input bit exc);
        @(negedge clk);
        rst = r; cnt_en = en; pc_ctrl = ctrl; read_data_1 = rd;
        signed_offset = off; target = tgt; exc_req = exc;
        model_step(1, 1'b1);
        model_step(0, 1'b0);
        exp_q1.push_back(model_out(1));
        exp_q0.push_back(model_out(0));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 2'd3, '0, '0, '0, 1'b0);
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 2'd3, '0, '0, '0, 1'b0);
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd3, '0, '0, '0, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every edge produces a full output set on both instances.
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            n_checks++;
            if ({pc1, slot1, epc1, bd1, aerr1, act1} !== e) begin
                n_errors++;
                $display("FAIL sb_ds1: got %h expected %h", {pc1, slot1, epc1, bd1, aerr1, act1}, e);
            end
        end
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            n_checks++;
            if ({pc0, slot0, epc0, bd0, aerr0, act0} !== e) begin
                n_errors++;
                $display("FAIL sb_ds0: got %h expected %h", {pc0, slot0, epc0, bd0, aerr0, act0}, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  c;
        logic [31:0] rd;
        int          sel;

        // Reset and stall
        do_reset();
        check("reset_pc", pc1, RV);
        check("reset_active", 32'(act1), 32'd1);
        check("reset_epc", epc1, 32'd0);
        stall(5);
        check("stall_pc", pc1, RV);
        seq(3);
        check("seq3_pc", pc1, 32'hBFC0000C);
        check("seq3_pc_ds0", pc0, 32'hBFC0000C);

        // Delayed branch backward
        seq(1);
        drive(1'b0, 1'b1, 2'd0, '0, 16'hFFFC, '0, 1'b0);
        check("br_slot_pc", pc1, 32'hBFC00014);
        check("br_slot_flag", 32'(slot1), 32'd1);
        check("br_ds0_pc", pc0, 32'hBFC00004);
        seq(1);
        check("br_tgt_pc", pc1, 32'hBFC00004);
        check("br_tgt_slot", 32'(slot1), 32'd0);

        // Delayed branch with a stall inside the slot
        do_reset();
        seq(4);
        drive(1'b0, 1'b1, 2'd0, '0, 16'hFFFC, '0, 1'b0);
        stall(2);
        check("br_stall_pc", pc1, 32'hBFC00014);
        check("br_stall_slot", 32'(slot1), 32'd1);
        seq(1);
        check("br_stall_tgt", pc1, 32'hBFC00004);

        // Jump-absolute, immediate mode
        do_reset();
        seq(8);
        check("j_pre_pc", pc0, 32'hBFC00020);
        drive(1'b0, 1'b1, 2'd1, '0, '0, 26'h0000100, 1'b0);
        check("j_ds0_pc", pc0, 32'hB0000400);
        check("j_ds1_pc", pc1, 32'hBFC00024);

        // Exception in delay slot
        do_reset();
        seq(4);
        drive(1'b0, 1'b1, 2'd0, '0, 16'hFFFC, '0, 1'b0);
        drive(1'b0, 1'b1, 2'd3, '0, '0, '0, 1'b1);
        check("exc_pc", pc1, EV);
        check("exc_epc", epc1, 32'hBFC00010);
        check("exc_bd", 32'(bd1), 32'd1);
        check("exc_slot", 32'(slot1), 32'd0);
        seq(1);
        check("exc_after_pc", pc1, EV + 32'd4);

        // Misaligned jump-register
        do_reset();
        seq(2);
        drive(1'b0, 1'b1, 2'd2, 32'h00001002, '0, '0, 1'b0);
        check("ae_pc", pc1, EV);
        check("ae_epc", epc1, 32'hBFC00008);
        check("ae_flag", 32'(aerr1), 32'd1);
        check("ae_bd", 32'(bd1), 32'd0);
        check("ae_flag_ds0", 32'(aerr0), 32'd1);
        seq(1);
        check("ae_clear", 32'(aerr1), 32'd0);

        // Halt via jump-register to 0
        do_reset();
        seq(12);
        drive(1'b0, 1'b1, 2'd2, 32'd0, '0, '0, 1'b0);
        check("halt_slot_pc", pc1, 32'hBFC00034);
        check("halt_ds0_active", 32'(act0), 32'd0);
        seq(1);
        check("halt_pc", pc1, 32'd0);
        check("halt_active", 32'(act1), 32'd0);
        drive(1'b0, 1'b1, 2'd3, '0, '0, '0, 1'b1);
        drive(1'b0, 1'b1, 2'd1, '0, '0, 26'h3FFFFFF, 1'b0);
        check("halt_hold_pc", pc1, 32'd0);
        check("halt_hold_pc_ds0", pc0, 32'd0);
        do_reset();
        check("halt_rst_pc", pc1, RV);
        check("halt_rst_active", 32'(act1), 32'd1);

        // Wrap-around to 0
        drive(1'b0, 1'b1, 2'd2, 32'hFFFFFFFC, '0, '0, 1'b0);
        check("wrap_ds0_pre", pc0, 32'hFFFFFFFC);
        seq(1);
        check("wrap_ds0_pc", pc0, 32'd0);
        check("wrap_ds0_active", 32'(act0), 32'd0);
        seq(1);
        check("wrap_ds1_active", 32'(act1), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            c = 2'($urandom_range(0, 3));
            rd = $urandom & 32'hFFFFFFFC;
            sel = $urandom_range(0, 19);
            if (sel == 0) rd = 32'd0;
            else if (sel < 3) rd[1:0] = 2'($urandom_range(1, 3));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), c, rd,
                  16'($urandom), 26'($urandom), ($urandom_range(0, 15) == 0));
        end

        for (int i = 0; i < 10 && (exp_q1.size() > 0 || exp_q0.size() > 0); i++) @(posedge clk);
        #3;
        if (exp_q1.size() > 0 || exp_q0.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q1.size() + exp_q0.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mips_pc_unit.md
# mips_pc_unit

Program-counter unit for the multicycle MIPS core, replacing the fixed-vector counter. Computes the next fetch address from the decoded control, with parametrised reset/exception vectors and an optional one-instruction branch delay slot held in a pending-target register. Captures EPC/BD on exceptions and raises a halt indication when execution reaches address 0. Sits between the control FSM (which drives `cnt_en`/`pc_ctrl`) and the instruction-fetch port.

## Interface

- `RESET_VECTOR`, 32'hBFC00000: PC after reset.
- `EXC_VECTOR`, 32'hBFC00380: PC loaded on an exception or address error.
- `DELAY_SLOT`, 1: 1 means the redirect takes effect after one delay-slot instruction; 0 means the redirect is immediate.

- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset; overrides all other inputs, including `cnt_en`=0.
- `cnt_en` in 1: advance enable; 0 means every register holds.
- `pc_ctrl` in 2: control code. 00 is branch-relative, 01 is jump-absolute, 10 is jump-register, 11 is sequential.
- `read_data_1` in 32: register operand for jump-register.
- `signed_offset` in 16: branch immediate, in words.
- `target` in 26: jump target field.
- `exc_req` in 1: exception request from the core.
- `pc` out 32: current fetch address.
- `in_slot` out 1: `pc` is a delay-slot instruction.
- `epc` out 32: exception PC.
- `bd` out 1: the last exception was taken in a delay slot.
- `addr_err` out 1: a misaligned jump-register was accepted on the previous enabled edge.
- `active` out 1: 0 once the core has halted at address 0.

## Operation

- Let P = `pc` and P4 = P+4. All arithmetic is modulo 2^32.
- Target T per `pc_ctrl`:
  - 00: T = P4 + (sign-extended `signed_offset` << 2). A sign bit of 1 gives a backward branch.
  - 01: T = {P4[31:28], `target`, 2'b00}.
  - 10: T = `read_data_1`.
  - 11: no redirect.
- States:
  - RUN is the normal state.
  - SLOT means a pending target is held and `pc` is the delay slot. Only reachable when DELAY_SLOT=1.
  - HALT means `pc` holds 0.
- Priority on an enabled edge in RUN or SLOT, highest first:
  1. `exc_req`
  2. misaligned jump-register: `pc_ctrl`=10 and `read_data_1[1:0]`≠0
  3. SLOT completion
  4. a new redirect
  5. sequential advance
- Exception (`exc_req`=1):
  - `pc` ← EXC_VECTOR, state ← RUN, pending target discarded.
  - In RUN: `epc` ← P, `bd` ← 0.
  - In SLOT: `epc` ← P−4 (the branch), `bd` ← 1.
- Misaligned jump-register:
  - Handled as an exception with `epc` ← P and `bd` ← 0.
  - `addr_err` ← 1 for one enabled edge; cleared on the next enabled edge.
- RUN with redirect (`pc_ctrl`≠11):
  - DELAY_SLOT=1: `pc` ← P4, pending ← T, state ← SLOT.
  - DELAY_SLOT=0: `pc` ← T.
- RUN with `pc_ctrl`=11: `pc` ← P4.
- SLOT: `pc` ← pending, state ← RUN. `pc_ctrl` is ignored, so a branch in a delay slot has no effect.
- Halt: any edge on which the new `pc` is 0 moves the state to HALT and sets `active` ← 0.
  - In HALT, `pc` stays 0 and `exc_req`/`pc_ctrl` are ignored until `rst`.
  - An exception vector of 0 does not halt.
- `in_slot` = (state == SLOT).

## Timing

- All outputs are registered. Inputs are sampled only on posedges where `cnt_en`=1 (or `rst`=1).
- Redirect latency:
  - DELAY_SLOT=1: T appears on `pc` 2 enabled edges after the redirect edge.
  - DELAY_SLOT=0: T appears 1 enabled edge after.
- Exception latency: EXC_VECTOR appears on `pc` 1 enabled edge after `exc_req` is sampled.
- With `cnt_en`=0, `pc`, state, pending, `epc`, `bd`, `addr_err` and `active` all hold. A stall inside SLOT keeps SLOT.
- Reset values: `pc`=RESET_VECTOR, state=RUN, pending=0, `in_slot`=0, `epc`=0, `bd`=0, `addr_err`=0, `active`=1.
- Reset during SLOT discards the pending target. Reset during HALT restarts at RESET_VECTOR.
- Wrap-around: P=32'hFFFFFFFC sequential gives `pc`=0, which triggers the halt.

## Test plan

- Reset/stall: assert `rst` with `cnt_en`=0 → `pc`=BFC00000, `active`=1. Then 5 edges with `cnt_en`=0 → `pc` unchanged. Then 3 sequential edges → BFC0000C.
- Delayed branch: DELAY_SLOT=1, P=BFC00010, `pc_ctrl`=00, offset=16'hFFFC → next `pc`=BFC00014 with `in_slot`=1, then `pc`=BFC00004 with `in_slot`=0. Stalling 2 cycles inside the slot → same sequence, `pc` held during the stall.
- Jump-absolute/immediate mode: DELAY_SLOT=0, P=BFC00020, `pc_ctrl`=01, `target`=26'h0000100 → `pc`=B0000400 after 1 edge.
- Exception in slot: at P=BFC00014 with `in_slot`=1, `exc_req`=1 → `pc`=BFC00380, `epc`=BFC00010, `bd`=1, pending target discarded.
- Misaligned jump-register: `pc_ctrl`=10, `read_data_1`=32'h00001002 at P=BFC00008 → `pc`=BFC00380, `epc`=BFC00008, `addr_err`=1 for one edge, then 0.
- Halt: jump-register to 0 at P=BFC00030 with DELAY_SLOT=1 → `pc`=BFC00034, then `pc`=0 with `active`=0. Further `exc_req`/`pc_ctrl` → `pc` stays 0. `rst` → `pc`=BFC00000, `active`=1.
